gtx_tx_framer: RTL and testbench

- Parametrised GTX transmit framer between the user datapath and the GTX TXDATA/TXCHARISK ports.
- Inserts a comma word on a programmable period and fills empty slots with idle words.
- Accepts user data through a valid/ready handshake; no user word is ever overwritten by a comma.
- Adds enable control, on-demand re-sync and an accepted-word counter.

---
 rtl/gtx_tx_framer.sv | 104 ++++++++++
 tb/tb_gtx_tx_framer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gtx_tx_framer.sv
// GTX transmit framer: registers user words toward TXDATA/TXCHARISK, inserts a
// comma word once per COMMA_PERIOD slots and fills unused slots with idle words.
// Upstream data arrives on a valid/ready handshake; no buffering inside.
module gtx_tx_framer #(
  parameter int unsigned BYTES        = 2,
  parameter int unsigned COMMA_PERIOD = 16,
  parameter logic [7:0]  K_COMMA      = 8'hBC,
  parameter logic [7:0]  K_IDLE       = 8'h1C
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic               sync_req_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [8*BYTES-1:0] s_data_i,
  output logic [BYTES-1:0]   ctrl_o,
  output logic [8*BYTES-1:0] data_o,
  output logic [31:0]        word_cnt_o
);

  localparam int unsigned    CntW   = $clog2(COMMA_PERIOD);
  localparam logic [CntW-1:0] CntMax = CntW'(COMMA_PERIOD - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    SelComma,
    SelIdle,
    SelData
  } sel_e;

  sel_e               sel;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               accept;
  logic [8*BYTES-1:0] data_q, data_d;
  logic [BYTES-1:0]   ctrl_q, ctrl_d;
  logic [31:0]        word_cnt_q, word_cnt_d;

  // Slot 0 of every period is reserved for the comma, so no accept there.
  assign s_ready_o = en_i && (cnt_q != '0) && !sync_req_i;

  // Pick this cycle's word type and the next slot position, in priority order.
  always_comb begin
    sel    = SelIdle;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (!en_i) begin
      sel   = SelComma;
      cnt_d = '0;
    end else if (sync_req_i || (cnt_q == '0)) begin
      // A sync request landing on slot 0 merges with the periodic comma.
      sel   = SelComma;
      cnt_d = CntOne;
    end else begin
      accept = s_valid_i;
      sel    = s_valid_i ? SelData : SelIdle;
      cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + CntOne;
    end
  end

  // Build the registered word, K-flags and accepted-word count.
  always_comb begin
    data_d     = {BYTES{K_IDLE}};
    ctrl_d     = {BYTES{1'b1}};
    word_cnt_d = word_cnt_q;
    unique case (sel)
      SelComma: begin
        data_d = {BYTES{K_COMMA}};
        ctrl_d = {BYTES{1'b1}};
      end
      SelData: begin
        data_d = s_data_i;
        ctrl_d = '0;
      end
      default: begin
        data_d = {BYTES{K_IDLE}};
        ctrl_d = {BYTES{1'b1}};
      end
    endcase
    if (accept) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      data_q     <= '0;
      ctrl_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign data_o     = data_q;
  assign ctrl_o     = ctrl_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_gtx_tx_framer.sv
// Directed bench for gtx_tx_framer: a slot-gap model checks the default
// instance every cycle; a small-period instance is checked against literals.
module tb_gtx_tx_framer;

  localparam int P = 16;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        en       = 1'b1;
  logic        sync_req = 1'b0;
  logic        s_valid  = 1'b0;
  logic [15:0] s_data   = 16'h0000;
  logic        s_ready;
  logic [1:0]  ctrl;
  logic [15:0] data_out;
  logic [31:0] word_cnt;

  logic        s_ready4;
  logic [3:0]  ctrl4;
  logic [31:0] data_out4;
  logic [31:0] word_cnt4;

  int vectors     = 0;
  int miscompares = 0;

  gtx_tx_framer #(
    .BYTES       (2),
    .COMMA_PERIOD(16),
    .K_COMMA     (8'hBC),
    .K_IDLE      (8'h1C)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .en_i      (en),
    .sync_req_i(sync_req),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_data_i  (s_data),
    .ctrl_o    (ctrl),
    .data_o    (data_out),
    .word_cnt_o(word_cnt)
  );

  gtx_tx_framer #(
    .BYTES       (4),
    .COMMA_PERIOD(4),
    .K_COMMA     (8'hBC),
    .K_IDLE      (8'hF7)
  ) dut4 (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .en_i      (1'b1),
    .sync_req_i(1'b0),
    .s_valid_i (1'b0),
    .s_ready_o (s_ready4),
    .s_data_i  (32'h0),
    .ctrl_o    (ctrl4),
    .data_o    (data_out4),
    .word_cnt_o(word_cnt4)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a comma is owed after reset/disable, on sync, or once P-1 words
  // have followed the previous comma.
  int          gap;
  bit          owed;
  logic [15:0] m_data;
  logic [1:0]  m_ctrl;
  logic [31:0] m_wc;

  function automatic bit m_ready();
    return en && !sync_req && !owed && (gap < P - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap    <= 0;
      owed   <= 1'b1;
      m_data <= 16'h0000;
      m_ctrl <= 2'b00;
      m_wc   <= 32'd0;
    end else if (!en) begin
      owed   <= 1'b1;
      m_data <= 16'hBCBC;
      m_ctrl <= 2'b11;
    end else if (sync_req || owed || gap == P - 1) begin
      gap    <= 0;
      owed   <= 1'b0;
      m_data <= 16'hBCBC;
      m_ctrl <= 2'b11;
    end else begin
      gap <= gap + 1;
      if (s_valid) begin
        m_data <= s_data;
        m_ctrl <= 2'b00;
        m_wc   <= m_wc + 32'd1;
      end else begin
        m_data <= 16'h1C1C;
        m_ctrl <= 2'b11;
      end
    end
  end

  // Per-cycle comparison of the default instance against the model.
  always @(negedge clk) begin
    check("model_ready", 32'(s_ready), 32'(m_ready()));
    check("model_data", 32'(data_out), 32'(m_data));
    check("model_ctrl", 32'(ctrl), 32'(m_ctrl));
    check("model_wcnt", word_cnt, m_wc);
  end

  // One clock; the bench's data source advances only when a word was taken.
  task automatic tick();
    bit acc;
    @(negedge clk);
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (acc) s_data = s_data + 16'd1;
  endtask

  // Async reset mid-cycle, verify immediate clear, release, take the first edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data_out), 32'h0);
    check("async_rst_ctrl", 32'(ctrl), 32'h0);
    check("async_rst_wcnt", word_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_comma", 32'(data_out), 32'hBCBC);
    check("restart_ctrl", 32'(ctrl), 32'h3);
  endtask

  initial begin
    logic [15:0] held;
    logic [31:0] wc_saved;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", 32'(data_out), 32'h0);
    check("reset_ctrl", 32'(ctrl), 32'h0);
    check("reset_wcnt", word_cnt, 32'h0);
    check("reset_ready", 32'(s_ready), 32'h0);

    // Idle link: comma, 15 idles, comma; small-period instance alongside.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      check("idle_data", 32'(data_out), (i % 16 == 0) ? 32'hBCBC : 32'h1C1C);
      check("idle_ctrl", 32'(ctrl), 32'h3);
      check("p4_data", data_out4, (i % 4 == 0) ? 32'hBCBCBCBC : 32'hF7F7F7F7);
      check("p4_ctrl", 32'(ctrl4), 32'hF);
    end

    // Continuous streaming from reset: 150 words in 160 cycles.
    s_valid = 1'b1;
    s_data  = 16'h0001;
    do_reset();
    tick();
    check("stream_first", 32'(data_out), 32'h0001);
    check("stream_first_ctrl", 32'(ctrl), 32'h0);
    repeat (158) tick();
    check("stream_wcnt_160", word_cnt, 32'd150);

    // Forced sync at slot 7 while streaming.
    s_data = 16'h0001;
    do_reset();
    repeat (6) tick();
    sync_req = 1'b1;
    #1;
    check("sync_ready_low", 32'(s_ready), 32'h0);
    tick();
    sync_req = 1'b0;
    check("sync_comma", 32'(data_out), 32'hBCBC);
    tick();
    check("sync_held_word", 32'(data_out), 32'h0007);
    repeat (14) tick();
    check("sync_last_before", 32'(data_out), 32'h0015);
    tick();
    check("sync_next_comma", 32'(data_out), 32'hBCBC);

    // Enable low for five cycles mid-stream.
    repeat (3) tick();
    wc_saved = 32'(s_data) - 32'd1;
    held     = s_data;
    en       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("en_low_ready", 32'(s_ready), 32'h0);
      tick();
      check("en_low_data", 32'(data_out), 32'hBCBC);
      check("en_low_wcnt", word_cnt, wc_saved);
    end
    en = 1'b1;
    tick();
    check("en_rise_comma", 32'(data_out), 32'hBCBC);
    tick();
    check("en_resume_word", 32'(data_out), 32'(held));

    // Reset mid-stream restarts with a comma.
    repeat (4) tick();
    do_reset();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
